drop_round_ctrl: RTL and testbench
==================================

Name: drop_round_ctrl

Overview:
Round sequencer for the catch-the-falling-object game. Owns the game FSM (idle, countdown, play, pause, over) and the frame-tick divider. Spawns one object at a time at a pseudo-random x position and advances its y on each tick. Judges catch versus miss against the player x and keeps score, miss count and speed level. Feeds the VGA object renderer and the score display.

Parameters:
TICK_DIV, 1666666, clk cycles per game tick (60 Hz at 100 MHz)
ROUNDS, 5, objects per game; legal range 1..15
CATCH_Y, 340, y at and below which a catch is judged
Y_FLOOR, 440, y at which an uncaught object is a miss
COUNT_TICKS, 180, countdown length in ticks
X_OFFSET, 45, added to the random 9-bit x

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse, already debounced
pause  in  1  one-cycle pulse, toggles pause
p_x  in  12  player paddle left x
obj_x  out  12  current object x
obj_y  out  12  current object y
obj_valid  out  1  object is drawable
state  out  3  IDLE=0, COUNT=1, SPAWN=2, FALL=3, PAUSE=4, OVER=5
score  out  4  catches this game
miss  out  4  misses this game
level  out  2  speed level 0..3
tick  out  1  one-cycle game tick strobe

Behaviour:
- Reset values: state IDLE; obj_x, obj_y, score, miss, level, tick all 0; obj_valid 0; divider 0; round counter 0; LFSR 16'hACE1.
- Tick divider:
  - Free-runs in every state.
  - tick=1 for the single cycle in which the divider equals TICK_DIV-1; the divider wraps to 0 on that cycle.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts every clk.
  - Never reaches 0.
- IDLE:
  - obj_valid=0.
  - On start: clear score, miss, level, round counter and countdown; go to COUNT.
- COUNT:
  - Countdown increments on tick.
  - Reaching COUNT_TICKS goes to SPAWN on the cycle after that tick.
- SPAWN (exactly 1 cycle):
  - obj_x <= LFSR[8:0] + X_OFFSET, zero-extended; range 45..556.
  - obj_y <= 0; obj_valid <= 1; go to FALL.
- FALL, on tick only, evaluated on the pre-update obj_y (priority order):
  1. Catch: obj_y >= CATCH_Y and ((p_x >= obj_x and p_x-obj_x <= 40) or (p_x < obj_x and obj_x-p_x <= 100)). Then score+1, level+1 saturating at 3, round counter+1, obj_valid <= 0.
  2. Else if obj_y == Y_FLOOR: miss+1, round counter+1, obj_valid <= 0.
  3. Else obj_y <= min(obj_y + level + 1, Y_FLOOR).
- After a catch or miss, next state is OVER if the round counter reached ROUNDS, else SPAWN. All updates land one cycle after the tick.
- Catch has priority over miss when both hold on the same tick.
- pause pulse in FALL goes to PAUSE; pause pulse in PAUSE returns to FALL.
  - In PAUSE: obj_x, obj_y, obj_valid frozen; ticks ignored; the divider keeps running.
- OVER:
  - obj_valid=0; score, miss and level held.
  - start goes to COUNT with the same clearing as from IDLE.
- Ignored inputs:
  - start is ignored outside IDLE and OVER.
  - pause is ignored outside FALL and PAUSE.
  - start and pause asserted together: each acts only in its own legal states.
- Width rules:
  - Subtractions are unsigned 12-bit, guarded by the comparisons above.
  - score and miss cannot wrap because ROUNDS <= 15.
- rst asserted in any state restores all reset values on the next edge, including a mid-fall object.

Decomposition:
- Shared package: state encodings, CATCH_WINDOW_RIGHT=40, CATCH_WINDOW_LEFT=100, LFSR seed 16'hACE1 and tap positions.
- One sub-module, lfsr16: clk, rst, 16-bit state out. Reused by other spawners.
- Divider, FSM and judge logic stay in drop_round_ctrl.

Test Plan:
All scenarios use TICK_DIV=4 and COUNT_TICKS=3.
1. Reset then idle 20 cycles -> tick period exactly 4 cycles; state 0; obj_valid 0; LFSR sequence matches the golden model from ACE1.
2. start, hold p_x=obj_x+10 -> COUNT lasts 3 ticks. SPAWN gives obj_x in 45..556. obj_y steps 1,2,3,... Catch judged on the first tick with obj_y>=340. Afterwards score=1, level=1 and the next object falls at 2 per tick.
3. p_x=obj_x+41, and again with p_x=obj_x-101 -> never caught; y saturates at 440; the next tick gives miss+1. Boundary p_x=obj_x+40 and p_x=obj_x-100 -> caught.
4. pause mid-fall for 10 ticks, then pause -> obj_y unchanged throughout PAUSE and resumes from the same value. A start pulse during PAUSE has no effect.
5. Play 5 rounds (3 catches, 2 misses) -> OVER with score=3, miss=2, level=3, obj_valid=0. A further start clears score and miss to 0 and enters COUNT.
6. rst asserted during FALL with obj_y=200 -> next cycle all outputs at reset values and state IDLE.

Source files
------------

// File: rtl/drop_round_ctrl_pkg.sv
// Shared definitions for the falling-object round sequencer: state
// encodings, catch window sizes and the LFSR seed/tap set used by spawners.
package drop_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_SPAWN = 3'd2,
        ST_FALL  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } round_state_t;

    // Paddle may sit this far right of the object (inclusive) and still catch.
    localparam logic [11:0] CATCH_WINDOW_RIGHT = 12'd40;
    // Paddle may sit this far left of the object (inclusive) and still catch.
    localparam logic [11:0] CATCH_WINDOW_LEFT  = 12'd100;

    // Non-zero seed; the polynomial is maximal so the register never hits 0.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // x^16+x^14+x^13+x^11+1 with the register shifting toward bit 0:
    // bit 0 <-> x^16, bit 2 <-> x^14, bit 3 <-> x^13, bit 5 <-> x^11.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic lfsr_feedback(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

    function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
        return {lfsr_feedback(s), s[15:1]};
    endfunction

    // Unsigned 12-bit distance test; each subtraction is guarded by its compare.
    function automatic logic in_catch_window(input logic [11:0] px,
                                             input logic [11:0] ox);
        if (px >= ox) begin
            return (px - ox) <= CATCH_WINDOW_RIGHT;
        end
        return (ox - px) <= CATCH_WINDOW_LEFT;
    endfunction

endpackage

// File: rtl/drop_round_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR, advancing every clock; shared by object spawners.
module lfsr16
    import drop_round_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    // Reload the seed on reset, otherwise shift one step per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= lfsr_advance(state);
        end
    end

endmodule

// File: rtl/drop_round_ctrl.sv
// Round sequencer for the catch-the-falling-object game: tick divider,
// game FSM, object spawn/fall and catch/miss judging with scoring.
module drop_round_ctrl
    import drop_round_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 1666666,
    parameter int ROUNDS      = 5,
    parameter int CATCH_Y     = 340,
    parameter int Y_FLOOR     = 440,
    parameter int COUNT_TICKS = 180,
    parameter int X_OFFSET    = 45
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic [11:0] p_x,
    output logic [11:0] obj_x,
    output logic [11:0] obj_y,
    output logic        obj_valid,
    output logic [2:0]  state,
    output logic [3:0]  score,
    output logic [3:0]  miss,
    output logic [1:0]  level,
    output logic        tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(COUNT_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_TICKS);
    localparam logic [3:0]       ROUND_LAST = 4'(ROUNDS);
    localparam logic [11:0]      CATCH_Y_V  = 12'(CATCH_Y);
    localparam logic [11:0]      FLOOR_V    = 12'(Y_FLOOR);
    localparam logic [11:0]      X_OFFSET_V = 12'(X_OFFSET);

    round_state_t     state_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;
    logic [3:0]       round_q;
    logic [3:0]       round_inc;
    logic [1:0]       level_inc;
    logic [15:0]      lfsr_state;
    logic             unused_lfsr_bits;
    logic             catch_hit;
    logic             floor_hit;
    logic [11:0]      y_step;
    logic [11:0]      y_next;
    logic [11:0]      spawn_x;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    // Only the low nine bits pick the spawn column.
    assign unused_lfsr_bits = ^lfsr_state[15:9];

    assign tick  = (div_q == DIV_LAST);
    assign state = state_q;

    // Free-running frame divider; wraps on the same cycle that tick is high.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Judge and next-position arithmetic, all taken from the pre-update values.
    always_comb begin
        count_inc = count_q + CNT_W'(1);
        round_inc = round_q + 4'd1;
        level_inc = (level == 2'd3) ? 2'd3 : level + 2'd1;
        catch_hit = (obj_y >= CATCH_Y_V) && in_catch_window(p_x, obj_x);
        floor_hit = (obj_y == FLOOR_V);
        y_step    = obj_y + {10'd0, level} + 12'd1;
        y_next    = (y_step > FLOOR_V) ? FLOOR_V : y_step;
        spawn_x   = {3'd0, lfsr_state[8:0]} + X_OFFSET_V;
    end

    // Game FSM; a pause pulse in FALL wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            obj_x     <= '0;
            obj_y     <= '0;
            obj_valid <= 1'b0;
            score     <= '0;
            miss      <= '0;
            level     <= '0;
            count_q   <= '0;
            round_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    obj_valid <= 1'b0;
                    if (start) begin
                        score   <= '0;
                        miss    <= '0;
                        level   <= '0;
                        round_q <= '0;
                        count_q <= '0;
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (tick) begin
                        count_q <= count_inc;
                        if (count_inc == COUNT_LAST) begin
                            state_q <= ST_SPAWN;
                        end
                    end
                end
                ST_SPAWN: begin
                    obj_x     <= spawn_x;
                    obj_y     <= '0;
                    obj_valid <= 1'b1;
                    state_q   <= ST_FALL;
                end
                ST_FALL: begin
                    if (pause) begin
                        state_q <= ST_PAUSE;
                    end else if (tick) begin
                        if (catch_hit) begin
                            score     <= score + 4'd1;
                            level     <= level_inc;
                            round_q   <= round_inc;
                            obj_valid <= 1'b0;
                            state_q   <= (round_inc == ROUND_LAST) ? ST_OVER : ST_SPAWN;
                        end else if (floor_hit) begin
                            miss      <= miss + 4'd1;
                            round_q   <= round_inc;
                            obj_valid <= 1'b0;
                            state_q   <= (round_inc == ROUND_LAST) ? ST_OVER : ST_SPAWN;
                        end else begin
                            obj_y <= y_next;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        state_q <= ST_FALL;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drop_round_ctrl.sv
// Self-checking bench for drop_round_ctrl: a cycle-stepped game model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_drop_round_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int ROUNDS      = 5;
    localparam int CATCH_Y     = 340;
    localparam int Y_FLOOR     = 440;
    localparam int COUNT_TICKS = 3;
    localparam int X_OFFSET    = 45;

    localparam int S_IDLE = 0, S_COUNT = 1, S_SPAWN = 2, S_FALL = 3, S_PAUSE = 4, S_OVER = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [11:0] p_x = 12'd0;
    logic [11:0] obj_x;
    logic [11:0] obj_y;
    logic        obj_valid;
    logic [2:0]  state;
    logic [3:0]  score;
    logic [3:0]  miss;
    logic [1:0]  level;
    logic        tick;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;
    bit px_track = 1'b0;
    int px_off = 0;

    // Model of the game, in plain integers
    int m_state = 0, m_div = 0, m_cnt = 0, m_round = 0;
    int m_x = 0, m_y = 0, m_valid = 0, m_score = 0, m_miss = 0, m_level = 0;
    int m_lfsr = 16'hACE1;

    drop_round_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .ROUNDS      (ROUNDS),
        .CATCH_Y     (CATCH_Y),
        .Y_FLOOR     (Y_FLOOR),
        .COUNT_TICKS (COUNT_TICKS),
        .X_OFFSET    (X_OFFSET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .p_x       (p_x),
        .obj_x     (obj_x),
        .obj_y     (obj_y),
        .obj_valid (obj_valid),
        .state     (state),
        .score     (score),
        .miss      (miss),
        .level     (level),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    function automatic int lfsr_next(input int s);
        int b;
        b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return (s >> 1) | (b << 15);
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_clear();
        m_score = 0; m_miss = 0; m_level = 0; m_round = 0; m_cnt = 0;
        m_state = S_COUNT;
    endtask

    task automatic model_round_done();
        m_round = m_round + 1;
        m_valid = 0;
        m_state = (m_round == ROUNDS) ? S_OVER : S_SPAWN;
    endtask

    // Advance the model by one clock using the inputs seen at this edge
    task automatic model_step();
        bit tk;
        int old_lfsr;
        int dx;
        if (rst) begin
            m_state = S_IDLE; m_div = 0; m_cnt = 0; m_round = 0;
            m_x = 0; m_y = 0; m_valid = 0; m_score = 0; m_miss = 0; m_level = 0;
            m_lfsr = 16'hACE1;
            return;
        end
        tk = (m_div == TICK_DIV - 1);
        old_lfsr = m_lfsr;
        m_div = tk ? 0 : m_div + 1;
        m_lfsr = lfsr_next(m_lfsr);
        case (m_state)
            S_IDLE, S_OVER: begin
                m_valid = 0;
                if (start) model_clear();
            end
            S_COUNT: if (tk) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == COUNT_TICKS) m_state = S_SPAWN;
            end
            S_SPAWN: begin
                m_x = (old_lfsr % 512) + X_OFFSET;
                m_y = 0;
                m_valid = 1;
                m_state = S_FALL;
            end
            S_FALL: begin
                if (pause) m_state = S_PAUSE;
                else if (tk) begin
                    dx = int'(p_x) - m_x;
                    if (m_y >= CATCH_Y && ((dx >= 0 && dx <= 40) || (dx < 0 && -dx <= 100))) begin
                        m_score = m_score + 1;
                        m_level = min_int(m_level + 1, 3);
                        model_round_done();
                    end else if (m_y == Y_FLOOR) begin
                        m_miss = m_miss + 1;
                        model_round_done();
                    end else begin
                        m_y = min_int(m_y + m_level + 1, Y_FLOOR);
                    end
                end
            end
            S_PAUSE: if (pause) m_state = S_FALL;
            default: ;
        endcase
    endtask

    always @(posedge clk) model_step();

    // Paddle follows the model's object with a chosen offset
    always @(negedge clk) if (px_track) p_x = 12'(m_x + px_off);

    // Whole-output comparison against the model every cycle
    always @(negedge clk) begin
        if (cmp_on) begin
            checks++;
            if (state !== 3'(m_state) || obj_x !== 12'(m_x) || obj_y !== 12'(m_y) ||
                obj_valid !== 1'(m_valid) || score !== 4'(m_score) || miss !== 4'(m_miss) ||
                level !== 2'(m_level) || tick !== (m_div == TICK_DIV - 1) ||
                dut.lfsr_state !== 16'(m_lfsr)) begin
                errors++;
                $display("[TB] FAIL model_cycle t=%0t act st=%0d x=%0d y=%0d v=%0d sc=%0d mi=%0d lv=%0d tk=%0d lfsr=%h exp st=%0d x=%0d y=%0d v=%0d sc=%0d mi=%0d lv=%0d tk=%0d lfsr=%h",
                         $time, state, obj_x, obj_y, obj_valid, score, miss, level, tick, dut.lfsr_state,
                         m_state, m_x, m_y, m_valid, m_score, m_miss, m_level,
                         (m_div == TICK_DIV - 1), m_lfsr[15:0]);
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout waiting", name);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        if (tick) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (int'(state) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (int'(state) != s) timeout_fail(name);
    endtask

    task automatic wait_y_ge(input int y, input int budget, input string name);
        int n = 0;
        while (int'(obj_y) < y && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (int'(obj_y) < y) timeout_fail(name);
    endtask

    // Wait for a tick and step to the cycle where its effect is visible
    task automatic next_tick_update(input string name);
        int n = 0;
        while (!tick && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!tick) timeout_fail(name);
        @(negedge clk);
    endtask

    task automatic apply_stimulus();
        int tick_cnt;
        int bad_phase;
        int held_y;
        int n;

        // Reset, then 20 idle cycles: tick period and LFSR start
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_on = 1'b1;
        rst = 1'b0;
        tick_cnt = 0;
        bad_phase = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) check_output("lfsr_seed", int'(dut.lfsr_state), 16'hACE1);
            if (i == 1) check_output("lfsr_step1", int'(dut.lfsr_state), 16'h5670);
            if (i == 2) check_output("lfsr_step2", int'(dut.lfsr_state), 16'hAB38);
            if (tick) begin
                tick_cnt++;
                if (i % 4 != 3) bad_phase++;
            end
        end
        check_output("idle_tick_count", tick_cnt, 5);
        check_output("idle_tick_phase", bad_phase, 0);
        check_output("idle_state", int'(state), S_IDLE);
        check_output("idle_valid", int'(obj_valid), 0);

        // Round 1: paddle 10 right of object, caught at y=340
        px_off = 10;
        px_track = 1'b1;
        pulse_start();
        check_output("start_to_count", int'(state), S_COUNT);
        tick_cnt = 0;
        n = 0;
        while (int'(state) == S_COUNT && n < 100) begin
            if (tick) tick_cnt++;
            @(negedge clk);
            n++;
        end
        check_output("count_ticks", tick_cnt, 3);
        check_output("count_to_spawn", int'(state), S_SPAWN);
        @(negedge clk);
        check_output("spawn_to_fall", int'(state), S_FALL);
        check_output("spawn_x_range", int'(obj_x >= 12'd45 && obj_x <= 12'd556), 1);
        check_output("spawn_valid", int'(obj_valid), 1);
        for (int k = 1; k <= 3; k++) begin
            next_tick_update("fall_step");
            check_output("fall_y_level0", int'(obj_y), k);
        end
        wait_state(S_SPAWN, 2000, "round1_end");
        check_output("r1_score", int'(score), 1);
        check_output("r1_level", int'(level), 1);
        check_output("r1_catch_y", int'(obj_y), 340);
        @(negedge clk);
        next_tick_update("r2_first_tick");
        check_output("r2_y_level1", int'(obj_y), 2);

        // Round 2: one pixel outside the right window, saturates then misses
        px_off = 41;
        n = 0;
        while (int'(obj_y) != 440 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        if (int'(obj_y) != 440) timeout_fail("r2_floor");
        check_output("r2_at_floor_state", int'(state), S_FALL);
        check_output("r2_at_floor_miss", int'(miss), 0);
        next_tick_update("r2_miss_tick");
        check_output("r2_miss", int'(miss), 1);
        check_output("r2_state", int'(state), S_SPAWN);
        check_output("r2_valid", int'(obj_valid), 0);

        // Round 3: one pixel outside the left window
        px_off = -101;
        @(negedge clk);
        wait_state(S_SPAWN, 1500, "round3_end");
        check_output("r3_miss", int'(miss), 2);
        check_output("r3_score", int'(score), 1);
        check_output("r3_floor_y", int'(obj_y), 440);

        // Round 4: right window edge is inclusive
        px_off = 40;
        @(negedge clk);
        wait_state(S_SPAWN, 1500, "round4_end");
        check_output("r4_score", int'(score), 2);
        check_output("r4_level", int'(level), 2);

        // Round 5: left edge (or right edge if too close to 0), with a pause
        @(negedge clk);
        px_off = (m_x >= 100) ? -100 : 40;
        wait_y_ge(90, 500, "r5_mid_fall");
        pulse_pause();
        check_output("pause_enter", int'(state), S_PAUSE);
        held_y = m_y;
        check_output("pause_y_entry", int'(obj_y), held_y);
        pulse_start();
        check_output("pause_ignores_start", int'(state), S_PAUSE);
        tick_cnt = 0;
        n = 0;
        while (tick_cnt < 10 && n < 100) begin
            @(negedge clk);
            n++;
            if (tick) tick_cnt++;
        end
        check_output("pause_ticks_seen", tick_cnt, 10);
        check_output("pause_y_frozen", int'(obj_y), held_y);
        check_output("pause_valid", int'(obj_valid), 1);
        pulse_pause();
        check_output("pause_exit", int'(state), S_FALL);
        next_tick_update("resume_tick");
        check_output("resume_y", int'(obj_y), held_y + 3);
        wait_state(S_OVER, 1500, "game_over");
        check_output("over_score", int'(score), 3);
        check_output("over_miss", int'(miss), 2);
        check_output("over_level", int'(level), 3);
        check_output("over_valid", int'(obj_valid), 0);
        pulse_start();
        check_output("restart_state", int'(state), S_COUNT);
        check_output("restart_score", int'(score), 0);
        check_output("restart_miss", int'(miss), 0);
        check_output("restart_level", int'(level), 0);

        // Reset in the middle of a fall
        wait_state(S_FALL, 100, "r6_fall");
        n = 0;
        while (int'(obj_y) != 200 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (int'(obj_y) != 200) timeout_fail("r6_y200");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_state", int'(state), S_IDLE);
        check_output("rst_obj_x", int'(obj_x), 0);
        check_output("rst_obj_y", int'(obj_y), 0);
        check_output("rst_valid", int'(obj_valid), 0);
        check_output("rst_score", int'(score), 0);
        check_output("rst_miss", int'(miss), 0);
        check_output("rst_level", int'(level), 0);
        check_output("rst_tick", int'(tick), 0);
        check_output("rst_lfsr", int'(dut.lfsr_state), 16'hACE1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        apply_stimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
